// File: rtl/input_debouncer.sv
// Board input conditioner: per-bit 2-flop synchronizer, shared sample prescaler and
// per-bit stability counter, producing a clean level plus one-cycle rise/fall pulses.
module input_debouncer #(
  parameter int unsigned WIDTH      = 21,
  parameter int unsigned TICK_DIV   = 10000,
  parameter int unsigned STABLE_CNT = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] DIN,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] RISE,
  output logic [WIDTH-1:0] FALL,
  output logic             TICK
);

  localparam int unsigned PreW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned CntW = $clog2(STABLE_CNT + 1);
  localparam logic [PreW-1:0] PreLast = PreW'(TICK_DIV - 1);
  localparam logic [CntW-1:0] CntLast = CntW'(STABLE_CNT - 1);

  logic [WIDTH-1:0] s1_q, s2_q;
  logic [PreW-1:0]  pre_q, pre_d;
  logic             tick_d;
  logic [CntW-1:0]  cnt_q [WIDTH];
  logic [CntW-1:0]  cnt_d [WIDTH];
  logic [WIDTH-1:0] q_d, rise_d, fall_d;

  // TICK is registered from the next prescaler value, so it is high exactly while
  // the prescaler holds its last count.
  always_comb begin
    pre_d  = (pre_q == PreLast) ? '0 : pre_q + PreW'(1);
    tick_d = (pre_d == PreLast);
  end

  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i]  = cnt_q[i];
      q_d[i]    = Q[i];
      rise_d[i] = 1'b0;
      fall_d[i] = 1'b0;
      if (TICK) begin
        if (s2_q[i] == Q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CntLast) begin
          cnt_d[i]  = '0;
          q_d[i]    = s2_q[i];
          rise_d[i] = s2_q[i];
          fall_d[i] = ~s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CntW'(1);
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      s1_q  <= '0;
      s2_q  <= '0;
      pre_q <= '0;
      TICK  <= 1'b0;
      cnt_q <= '{default: '0};
      Q     <= '0;
      RISE  <= '0;
      FALL  <= '0;
    end else begin
      s1_q  <= DIN;
      s2_q  <= s1_q;
      pre_q <= pre_d;
      TICK  <= tick_d;
      cnt_q <= cnt_d;
      Q     <= q_d;
      RISE  <= rise_d;
      FALL  <= fall_d;
    end
  end

endmodule

// File: tb/tb_input_debouncer.sv
// Bench for input_debouncer: tick-history reference model checked every cycle,
// plus directed scenarios with hand-computed latency and pulse expectations.
module tb_input_debouncer;
  localparam int unsigned W  = 21;
  localparam int unsigned TD = 4;
  localparam int unsigned SC = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] din = '0;
  logic [W-1:0] q, rise, fall;
  logic         tick;

  input_debouncer #(.WIDTH(W), .TICK_DIV(TD), .STABLE_CNT(SC)) dut (
    .CLK(clk), .RESET(rst), .DIN(din), .Q(q), .RISE(rise), .FALL(fall), .TICK(tick)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_range(input string name, input int val, input int lo, input int hi);
    checks++;
    if (val < lo || val > hi) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d..%0d t=%0t", name, val, lo, hi, $time);
    end
  endtask

  // Reference model: a bit takes a new level once the last SC tick samples of its
  // synchronized input all agree on a value different from the current level.
  logic [W-1:0] m_h1, m_h2, m_q, m_rise, m_fall, all1, any1;
  logic         m_tick;
  int           m_n;
  logic [W-1:0] m_hist[$];

  initial begin
    m_h1 = '0; m_h2 = '0; m_q = '0; m_rise = '0; m_fall = '0; m_tick = 1'b0; m_n = 0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_h1 = '0; m_h2 = '0; m_q = '0; m_rise = '0; m_fall = '0; m_tick = 1'b0; m_n = 0;
        m_hist.delete();
      end else begin
        m_rise = '0;
        m_fall = '0;
        if (m_n % TD == TD - 1) begin
          m_hist.push_front(m_h2);
          if (m_hist.size() > SC) void'(m_hist.pop_back());
          if (m_hist.size() == SC) begin
            all1 = '1;
            any1 = '0;
            foreach (m_hist[k]) begin
              all1 &= m_hist[k];
              any1 |= m_hist[k];
            end
            m_rise = all1 & ~m_q;
            m_fall = ~any1 & m_q;
            m_q    = (m_q | m_rise) & ~m_fall;
          end
        end
        m_h2   = m_h1;
        m_h1   = din;
        m_n++;
        m_tick = (m_n % TD == TD - 1);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("model_Q", q, m_q);
      chk("model_RISE", rise, m_rise);
      chk("model_FALL", fall, m_fall);
      chk("model_TICK", W'(tick), W'(m_tick));
    end
  end

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lat;
    int cnt;
    int rc[W];
    logic [W-1:0] mask, acc;
    logic found;

    // 1. Reset with all inputs high, then release.
    din = '1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_Q", q, '0);
      chk("rst_pulses", rise | fall, '0);
    end
    edge1();
    rst = 1'b0;
    lat = 0;
    foreach (rc[i]) rc[i] = 0;
    for (int c = 1; c <= 20; c++) begin
      edge1();
      if (q == '1 && lat == 0) lat = c;
      for (int i = 0; i < W; i++) rc[i] += int'(rise[i]);
    end
    chk_range("rst_release_latency", lat, 2, 14);
    mask = '0;
    for (int i = 0; i < W; i++) mask[i] = (rc[i] == 1);
    chk("rst_one_rise_per_bit", mask, '1);

    // 2. Clean step on bit 0.
    din = '0;
    repeat (20) edge1();
    din = W'(1);
    lat = 0;
    cnt = 0;
    for (int c = 1; c <= 20; c++) begin
      edge1();
      if (q[0] && lat == 0) begin
        lat = c;
        chk("step_rise_at_q", W'(rise[0]), W'(1));
      end else if (lat != 0 && c == lat + 1) begin
        chk("step_rise_one_cycle", W'(rise[0]), W'(0));
      end
      cnt += int'(rise[0]);
      chk("step_no_fall", fall, '0);
    end
    chk_range("step_latency", lat, 11, 14);
    chk_range("step_rise_count", cnt, 1, 1);
    chk("step_other_bits", q, W'(1));

    // 3. Bounce on bit 3, phased so every tick sample sees the low half.
    do edge1(); while (m_n % 2 != 0);
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      din[3] = (k % 2 == 0);
      edge1();
      chk("bounce_q3_held", W'(q[3]), W'(0));
      cnt += int'(rise[3]);
    end
    chk_range("bounce_no_rise", cnt, 0, 0);
    din[3] = 1'b1;
    lat = 0;
    cnt = 0;
    for (int c = 1; c <= 20; c++) begin
      edge1();
      if (rise[3] && lat == 0) lat = c;
      cnt += int'(rise[3]);
    end
    chk_range("bounce_hold_latency", lat, 1, 14);
    chk_range("bounce_rise_count", cnt, 1, 1);

    // 4. Five-cycle glitch on bit 7.
    repeat (10) edge1();
    din[7] = 1'b1;
    acc = '0;
    found = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      edge1();
      if (c == 5) din[7] = 1'b0;
      acc |= rise | fall;
      found |= q[7];
    end
    chk("glitch_no_pulse", acc, '0);
    chk("glitch_q7", W'(found), W'(0));

    // 5. Simultaneous falls on [20:16] and rises on [4:0].
    din = 21'h1F0000;
    repeat (30) edge1();
    chk("simul_setup_q", q, 21'h1F0000);
    din = 21'h00001F;
    found = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      edge1();
      if (!found && (rise | fall) != '0) begin
        found = 1'b1;
        chk("simul_rise", rise, 21'h00001F);
        chk("simul_fall", fall, 21'h1F0000);
        edge1();
        chk("simul_pulse_end", rise | fall, '0);
      end
    end
    chk("simul_seen", W'(found), W'(1));

    // 6. Reset after two of three qualifying ticks on bit 1.
    din = '0;
    repeat (30) edge1();
    do edge1(); while (m_n % TD != 1);
    din[1] = 1'b1;
    repeat (8) edge1();
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("midrst_Q", q, '0);
      chk("midrst_pulses", rise | fall, '0);
    end
    edge1();
    rst = 1'b0;
    lat = 0;
    cnt = 0;
    for (int c = 1; c <= 20; c++) begin
      edge1();
      if (q[1] && lat == 0) lat = c;
      cnt += int'(rise[1]);
    end
    chk_range("midrst_latency", lat, 11, 14);
    chk_range("midrst_rise_count", cnt, 1, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
